// File: rtl/arm_isa_pkg.sv
// Shared ARM ISA encodings used by both the decode stage and the instruction encoder.
package arm_isa_pkg;

  typedef enum logic [3:0] {
    CMD_DP   = 4'd0,
    CMD_BX   = 4'd1,
    CMD_B    = 4'd2,
    CMD_BL   = 4'd3,
    CMD_LDR0 = 4'd4,
    CMD_LDR1 = 4'd5,
    CMD_STR0 = 4'd6,
    CMD_STR1 = 4'd7,
    CMD_SWP  = 4'd8
  } cmd_e;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0]  COND_AL    = 4'hE;
  localparam logic [3:0]  COND_NV    = 4'hF;
  localparam logic [23:0] BX_PATTERN = 24'h12_FFF1;
  localparam logic [7:0]  SWP_MID    = 8'b0000_1001;

  localparam logic [1:0] OP2_IMM_SHIFT = 2'd0;
  localparam logic [1:0] OP2_REG_SHIFT = 2'd1;
  localparam logic [1:0] OP2_ROT_IMM   = 2'd2;
  localparam logic [1:0] OP2_ILLEGAL   = 2'd3;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  cond;
    logic [3:0]  alu_op;
    logic        s;
    logic        p;
    logic        u;
    logic        w;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [1:0]  op2_sel;
    logic [1:0]  shift_type;
    logic [4:0]  imm5;
    logic [11:0] imm12;
    logic [23:0] imm24;
  } enc_fields_t;

endpackage

// File: rtl/arm_enc_fifo2.sv
// Two-entry FIFO with valid/ready on both sides; ready is a function of occupancy only.
module arm_enc_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  // An empty buffer presents zero so the output word reads 0 out of reset.
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/arm_inst_encoder.sv
// Packs a decoded ARM field bundle into a 32-bit instruction word tagged with a
// sequential byte address, buffered through a 2-entry output FIFO.
module arm_inst_encoder
  import arm_isa_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cmd,
  input  logic [3:0]        cond,
  input  logic [3:0]        alu_op,
  input  logic              s,
  input  logic              p,
  input  logic              u,
  input  logic              w,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rm,
  input  logic [3:0]        rs,
  input  logic [1:0]        op2_sel,
  input  logic [1:0]        shift_type,
  input  logic [4:0]        imm5,
  input  logic [11:0]       imm12,
  input  logic [23:0]       imm24,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky
);

  function automatic logic is_reject(enc_fields_t f);
    return (f.cmd > 4'(CMD_SWP)) ||
           ((f.cmd == 4'(CMD_DP)) && (f.op2_sel == OP2_ILLEGAL)) ||
           (f.cond == COND_NV);
  endfunction

  function automatic logic [31:0] encode(enc_fields_t f);
    logic [31:0] word;
    logic [11:0] op2;
    logic        test_op;
    logic        s_eff;
    logic [3:0]  rn_eff;
    logic [3:0]  rd_eff;
    logic        load;
    // TST/TEQ/CMP/CMN always set flags and have no destination; MOV/MVN have no Rn.
    test_op = (f.alu_op[3:2] == 2'b10);
    s_eff   = test_op ? 1'b1 : f.s;
    rd_eff  = test_op ? 4'h0 : f.rd;
    rn_eff  = ((f.alu_op == OP_MOV) || (f.alu_op == OP_MVN)) ? 4'h0 : f.rn;
    load    = (f.cmd == 4'(CMD_LDR0)) || (f.cmd == 4'(CMD_LDR1));
    case (f.op2_sel)
      OP2_IMM_SHIFT: op2 = {f.imm5, f.shift_type, 1'b0, f.rm};
      OP2_REG_SHIFT: op2 = {f.rs, 1'b0, f.shift_type, 1'b1, f.rm};
      default:       op2 = f.imm12;
    endcase
    case (f.cmd)
      4'(CMD_DP):   word = {f.cond, 2'b00, (f.op2_sel == OP2_ROT_IMM), f.alu_op,
                            s_eff, rn_eff, rd_eff, op2};
      4'(CMD_BX):   word = {f.cond, BX_PATTERN, f.rm};
      4'(CMD_B):    word = {f.cond, 4'b1010, f.imm24};
      4'(CMD_BL):   word = {f.cond, 4'b1011, f.imm24};
      4'(CMD_LDR0),
      4'(CMD_STR0): word = {f.cond, 3'b010, f.p, f.u, 1'b0, f.w, load,
                            f.rn, f.rd, f.imm12};
      4'(CMD_LDR1),
      4'(CMD_STR1): word = {f.cond, 3'b011, f.p, f.u, 1'b0, f.w, load,
                            f.rn, f.rd, f.imm5, f.shift_type, 1'b0, f.rm};
      4'(CMD_SWP):  word = {f.cond, 8'b0001_0000, f.rn, f.rd, SWP_MID, f.rm};
      default:      word = '0;
    endcase
    return word;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  enc_fields_t       w_fields;
  logic [31:0]       w_instr;
  logic              w_reject;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_err_sticky;

  assign w_fields = '{cmd: cmd, cond: cond, alu_op: alu_op, s: s, p: p, u: u, w: w,
                      rn: rn, rd: rd, rm: rm, rs: rs, op2_sel: op2_sel,
                      shift_type: shift_type, imm5: imm5, imm12: imm12, imm24: imm24};
  assign w_instr  = encode(w_fields);
  assign w_reject = is_reject(w_fields);
  assign w_accept = in_valid && in_ready;
  // Rejected bundles complete the handshake but never reach the buffer.
  assign w_push   = w_accept && !w_reject;
  assign w_pop    = out_valid && out_ready;

  arm_enc_fifo2 #(.DATA_W(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_push),
    .o_ready (in_ready),
    .i_data  (w_instr),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= BASE_ADDR;
      r_word_cnt   <= '0;
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr     <= r_addr + ADDR_W'(4);
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
      if (w_accept && w_reject) begin
        r_err_cnt    <= sat_inc(r_err_cnt);
        r_err_sticky <= 1'b1;
      end
    end
  end

  assign out_addr   = r_addr;
  assign word_cnt   = r_word_cnt;
  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_arm_inst_encoder.sv
// Directed self-checking bench for arm_inst_encoder with hand-computed instruction words.
module tb_arm_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cmd, cond, alu_op, rn, rd, rm, rs;
  logic        s, p, u, w;
  logic [1:0]  op2_sel, shift_type;
  logic [4:0]  imm5;
  logic [11:0] imm12;
  logic [23:0] imm24;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [15:0] word_cnt;
  logic [15:0] err_cnt;
  logic        err_sticky;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr;
  logic [15:0] exp_wcnt;

  always #5 clk = ~clk;

  arm_inst_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .cond(cond), .alu_op(alu_op), .s(s), .p(p), .u(u), .w(w),
    .rn(rn), .rd(rd), .rm(rm), .rs(rs), .op2_sel(op2_sel),
    .shift_type(shift_type), .imm5(imm5), .imm12(imm12), .imm24(imm24),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .word_cnt(word_cnt), .err_cnt(err_cnt),
    .err_sticky(err_sticky)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_fields;
    in_valid = 0; cmd = 0; cond = 4'hE; alu_op = 0; s = 0; p = 0; u = 0; w = 0;
    rn = 0; rd = 0; rm = 0; rs = 0; op2_sel = 0; shift_type = 0;
    imm5 = 0; imm12 = 0; imm24 = 0;
  endtask

  // Hold in_valid until the handshake completes; returns #1 after the accepting edge.
  task automatic send;
    bit ok;
    ok = 0;
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  // Take one word from the output, capturing data and address before the popping edge.
  task automatic pop(output logic [31:0] instr, output logic [31:0] addr);
    bit ok;
    ok = 0;
    instr = 'x;
    addr = 'x;
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        instr = out_instr;
        addr = out_addr;
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    out_ready = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pop_timeout: out_valid stayed %b, required 1", out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1; out_ready = 0;
    clear_fields();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_handshake: out_valid/in_ready %b%b, required 01", out_valid, in_ready);
    end
    checks++;
    if (out_instr !== 32'h0 || out_addr !== BASE) begin
      errors++;
      $display("FAIL reset_data: instr %h addr %h, required 00000000 %h", out_instr, out_addr, BASE);
    end
    checks++;
    if (word_cnt !== 0 || err_cnt !== 0 || err_sticky !== 0) begin
      errors++;
      $display("FAIL reset_counters: word_cnt %0d err_cnt %0d sticky %b, required 0 0 0",
               word_cnt, err_cnt, err_sticky);
    end
    exp_addr = BASE;
    exp_wcnt = 0;
  endtask

  task automatic test_dp_add;
    logic [31:0] gi, ga;
    clear_fields();
    alu_op = 4'h4; rn = 2; rd = 1; op2_sel = 2; imm12 = 12'h005;
    send();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hE282_1005 || out_addr !== exp_addr) begin
      errors++;
      $display("FAIL dp_add_latency: valid %b instr %h addr %h, required 1 e2821005 %h",
               out_valid, out_instr, out_addr, exp_addr);
    end
    pop(gi, ga);
    exp_addr += 4; exp_wcnt += 1;
    checks++;
    if (word_cnt !== exp_wcnt || out_addr !== exp_addr) begin
      errors++;
      $display("FAIL dp_add_pop: word_cnt %0d addr %h, required %0d %h",
               word_cnt, out_addr, exp_wcnt, exp_addr);
    end
  endtask

  // Each vector: fields set, send, pop, compare word and address.
  task automatic test_encodings;
    logic [31:0] exp_i [9];
    logic [31:0] gi, ga;
    exp_i = '{32'hE153_0004, 32'h0A00_0010, 32'hE12F_FF1E, 32'hE591_0004,
              32'hE104_2093, 32'hE082_1413, 32'hE781_0125, 32'hE3B0_1005,
              32'hEBFF_FFFE};
    for (int k = 0; k < 9; k++) begin
      clear_fields();
      case (k)
        0: begin alu_op = 4'hA; rn = 3; rd = 7; rm = 4; op2_sel = 0; imm5 = 0; end
        1: begin cmd = 2; cond = 4'h0; imm24 = 24'h10; end
        2: begin cmd = 1; rm = 4'hE; end
        3: begin cmd = 4; p = 1; u = 1; w = 0; rn = 1; rd = 0; imm12 = 12'h004; end
        4: begin cmd = 8; rn = 4; rd = 2; rm = 3; end
        5: begin alu_op = 4'h4; rn = 2; rd = 1; rs = 4; rm = 3; op2_sel = 1; end
        6: begin cmd = 7; p = 1; u = 1; rn = 1; rd = 0; imm5 = 2; shift_type = 1; rm = 5; end
        7: begin alu_op = 4'hD; s = 1; rn = 7; rd = 1; op2_sel = 2; imm12 = 12'h005; end
        default: begin cmd = 3; imm24 = 24'hFF_FFFE; end
      endcase
      send();
      pop(gi, ga);
      checks++;
      if (gi !== exp_i[k] || ga !== exp_addr) begin
        errors++;
        $display("FAIL encode_%0d: instr %h addr %h, required %h %h", k, gi, ga, exp_i[k], exp_addr);
      end
      exp_addr += 4; exp_wcnt += 1;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] gi [3];
    logic [31:0] ga [3];
    int got;
    bit acc;
    out_ready = 0;
    for (int k = 1; k <= 2; k++) begin
      clear_fields();
      alu_op = 4'h4; rn = 2; rd = 1; op2_sel = 2; imm12 = 12'(k);
      send();
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: in_ready %b, required 0", in_ready);
    end
    imm12 = 12'h003;
    in_valid = 1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (in_ready !== 1'b0 || out_instr !== 32'hE282_1001 || out_addr !== exp_addr) begin
      errors++;
      $display("FAIL full_hold: in_ready %b instr %h addr %h, required 0 e2821001 %h",
               in_ready, out_instr, out_addr, exp_addr);
    end
    got = 0;
    out_ready = 1;
    for (int i = 0; i < 20 && got < 3; i++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        gi[got] = out_instr;
        ga[got] = out_addr;
        got++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 0;
    end
    out_ready = 0;
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got <= k || gi[k] !== (32'hE282_1001 + 32'(k)) || ga[k] !== exp_addr) begin
        errors++;
        $display("FAIL b2b_word_%0d: instr %h addr %h, required %h %h",
                 k, gi[k], ga[k], 32'hE282_1001 + 32'(k), exp_addr);
      end
      exp_addr += 4; exp_wcnt += 1;
    end
    checks++;
    if (word_cnt !== exp_wcnt || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: word_cnt %0d out_valid %b, required %0d 0", word_cnt, out_valid, exp_wcnt);
    end
  endtask

  task automatic test_reject;
    logic [31:0] gi, ga;
    clear_fields();
    cmd = 9;
    send();
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== 16'd1 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL reject_cmd9: out_valid %b err_cnt %0d sticky %b, required 0 1 1",
               out_valid, err_cnt, err_sticky);
    end
    clear_fields();
    op2_sel = 3;
    send();
    clear_fields();
    cond = 4'hF; cmd = 2;
    send();
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== 16'd3 || out_addr !== exp_addr) begin
      errors++;
      $display("FAIL reject_more: out_valid %b err_cnt %0d addr %h, required 0 3 %h",
               out_valid, err_cnt, out_addr, exp_addr);
    end
    clear_fields();
    alu_op = 4'h4; rn = 2; rd = 1; op2_sel = 2; imm12 = 12'h005;
    send();
    pop(gi, ga);
    checks++;
    if (gi !== 32'hE282_1005 || ga !== exp_addr) begin
      errors++;
      $display("FAIL reject_next: instr %h addr %h, required e2821005 %h", gi, ga, exp_addr);
    end
    exp_addr += 4; exp_wcnt += 1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] gi, ga;
    out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      clear_fields();
      cmd = 2; imm24 = 24'(k);
      send();
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_full: out_valid %b in_ready %b, required 1 0", out_valid, in_ready);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_addr !== BASE) begin
      errors++;
      $display("FAIL mid_reset_state: out_valid %b in_ready %b addr %h, required 0 1 %h",
               out_valid, in_ready, out_addr, BASE);
    end
    checks++;
    if (word_cnt !== 0 || err_cnt !== 0 || err_sticky !== 0) begin
      errors++;
      $display("FAIL mid_reset_counters: word_cnt %0d err_cnt %0d sticky %b, required 0 0 0",
               word_cnt, err_cnt, err_sticky);
    end
    clear_fields();
    cmd = 3; imm24 = 24'h00_0040;
    send();
    pop(gi, ga);
    checks++;
    if (gi !== 32'hEB00_0040 || ga !== BASE) begin
      errors++;
      $display("FAIL post_reset_word: instr %h addr %h, required eb000040 %h", gi, ga, BASE);
    end
  endtask

  initial begin
    test_reset();
    test_dp_add();
    test_encodings();
    test_back_to_back();
    test_reject();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
